display_scan_mux: RTL and testbench

//   Time-multiplexed scanner for an N-digit common-anode 7-segment display.

---
 rtl/display_pkg.sv | 30 +++
 rtl/display_scan_mux_scan_prescaler.sv | 57 +++++
 rtl/display_scan_mux.sv | 123 ++++++++++++
 tb/tb_display_scan_mux.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package display_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned LZ_W       = 4 * MAX_DIGITS;

  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic {PH_GAP, PH_DRIVE} phase_e;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

  // Bit i set when digit i and every digit above it are zero with no decimal point.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [LZ_W-1:0] digits,
                                                    input logic [MAX_DIGITS-1:0] dp);
    logic [MAX_DIGITS-1:0] mask;
    logic                  lead;
    mask = '0;
    lead = 1'b1;
    for (int i = int'(MAX_DIGITS) - 1; i > 0; i--) begin
      lead    = lead & (digits[4*i +: 4] == 4'd0) & ~dp[i];
      mask[i] = lead;
    end
    return mask;
  endfunction

endpackage

// File: rtl/display_scan_mux_scan_prescaler.sv
// Slot counter and digit index for the display scanner; tracks the gap/drive phase of each slot.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          slot_start_c,
  output logic                          drive_phase_c,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          wrap_c
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  phase_e           phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= (BLANK_CYCLES == 0) ? PH_DRIVE : PH_GAP;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

  // phase_q always describes the slot position held in cnt_q.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    wrap_c = 1'b0;
    if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d  = '0;
        wrap_c = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    phase_d       = (cnt_d < CNT_W'(BLANK_CYCLES)) ? PH_GAP : PH_DRIVE;
    slot_start_c  = (cnt_q == '0);
    drive_phase_c = (phase_q == PH_DRIVE);
  end

  assign idx = idx_q;

endmodule

// File: rtl/display_scan_mux.sv
// Multiplexed N-digit 7-segment scanner with blank gaps and frame-aligned updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              bcd_out,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned DW    = 4 * NUM_DIGITS;

  logic             slot_start_c, drive_phase_c, wrap_c;
  logic [IDX_W-1:0] idx;

  scan_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_start_c (slot_start_c),
    .drive_phase_c(drive_phase_c),
    .idx          (idx),
    .wrap_c       (wrap_c)
  );

  logic [DW-1:0]         pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DW-1:0]         act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  bcd_t                  bcd_out_q, bcd_out_d;
  logic                  blank_q, blank_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  dp_out_q, dp_out_d;
  logic                  frame_start_q, frame_start_d;
  bcd_t                  code_c;
  logic                  lz_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_vld_q    <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      bcd_out_q     <= '0;
      blank_q       <= 1'b1;
      digit_en_q    <= '0;
      dp_out_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_vld_q    <= pend_vld_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      bcd_out_q     <= bcd_out_d;
      blank_q       <= blank_d;
      digit_en_q    <= digit_en_d;
      dp_out_q      <= dp_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_vld_d    = pend_vld_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    bcd_out_d     = bcd_out_q;
    dp_out_d      = dp_out_q;

    // Active word only changes at the frame boundary; a load on that same cycle waits a frame.
    if (wrap_c && pend_vld_q) begin
      act_digits_d = pend_digits_q;
      act_dp_d     = pend_dp_q;
      pend_vld_d   = 1'b0;
    end
    if (load) begin
      pend_digits_d = digits_in;
      pend_dp_d     = dp_in;
      pend_vld_d    = 1'b1;
    end

    code_c = bcd_t'(act_digits_q >> {idx, 2'b00});
`ifdef LEADING_ZERO_BLANK_EN
    lz_c = |(lz_mask(LZ_W'(act_digits_q), MAX_DIGITS'(act_dp_q)) & onehot(3'(idx)));
`else
    lz_c = 1'b0;
`endif

    if (slot_start_c) begin
      bcd_out_d = code_c;
      dp_out_d  = act_dp_q[idx];
    end
    digit_en_d    = drive_phase_c ? NUM_DIGITS'(onehot(3'(idx))) : '0;
    blank_d       = ~drive_phase_c | (code_c > BCD_MAX) | lz_c;
    frame_start_d = slot_start_c & (idx == '0);
  end

  assign bcd_out     = bcd_out_q;
  assign blank       = blank_q;
  assign digit_en    = digit_en_q;
  assign dp_out      = dp_out_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux (4 digits, 8-cycle slots, 2-cycle gap).
module tb_display_scan_mux;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_out;
  logic        blank;
  logic [3:0]  digit_en;
  logic        dp_out;
  logic        frame_start;

  int n_assert;
  int n_fail;

  display_scan_mux #(
    .NUM_DIGITS  (4),
    .SLOT_CYCLES (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .bcd_out    (bcd_out),
    .blank      (blank),
    .digit_en   (digit_en),
    .dp_out     (dp_out),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'h0);
    chk({tag, "_blank"}, 32'(blank), 32'h1);
    chk({tag, "_en"}, 32'(digit_en), 32'h0);
    chk({tag, "_dp"}, 32'(dp_out), 32'h0);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  // Entered with outputs showing cycle 0 of slot s; leaves at cycle 0 of the next slot.
  // la = j strobes load on the j-th clock edge of the slot (0 = no load).
  task automatic check_slot(input int s, input logic [3:0] code, input logic dpb,
                            input logic blk, input int la,
                            input logic [15:0] ld, input logic [3:0] lp);
    logic [3:0] en_exp;
    en_exp = 4'b0001 << s;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) begin
        if (la == j) begin
          load = 1'b1; digits_in = ld; dp_in = lp;
        end
        tick();
        load = 1'b0;
      end
      chk($sformatf("fs_s%0d_c%0d", s, j), 32'(frame_start), 32'((j == 0) && (s == 0)));
      chk($sformatf("en_s%0d_c%0d", s, j), 32'(digit_en), (j < 2) ? 32'h0 : 32'(en_exp));
      chk($sformatf("blank_s%0d_c%0d", s, j), 32'(blank), (j < 2) ? 32'h1 : 32'(blk));
      chk($sformatf("bcd_s%0d_c%0d", s, j), 32'(bcd_out), 32'(code));
      chk($sformatf("dp_s%0d_c%0d", s, j), 32'(dp_out), 32'(dpb));
    end
    if (la == 8) begin
      load = 1'b1; digits_in = ld; dp_in = lp;
    end
    tick();
    load = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] dig, input logic [3:0] dpv, input logic [3:0] blk,
                           input int ls1, input int la1, input logic [15:0] ld1, input logic [3:0] lp1,
                           input int ls2, input int la2, input logic [15:0] ld2, input logic [3:0] lp2);
    for (int s = 0; s < 4; s++) begin
      if (s == ls1)
        check_slot(s, dig[s*4 +: 4], dpv[s], blk[s], la1, ld1, lp1);
      else if (s == ls2)
        check_slot(s, dig[s*4 +: 4], dpv[s], blk[s], la2, ld2, lp2);
      else
        check_slot(s, dig[s*4 +: 4], dpv[s], blk[s], 0, 16'h0, 4'h0);
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    tick(); tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // Frame 0: cleared active word; load 1234/dp 0010 mid-frame.
    run_frame(16'h0000, 4'b0000, LZ ? 4'b1110 : 4'b0000,
              2, 3, 16'h1234, 4'b0010, -1, 0, 16'h0, 4'h0);
    // Frame 1: 1234 shown; 5678 loaded in slot 2 must not tear this frame.
    run_frame(16'h1234, 4'b0010, 4'b0000,
              2, 3, 16'h5678, 4'b0000, -1, 0, 16'h0, 4'h0);
    // Frame 2: 5678; two loads, the later one wins.
    run_frame(16'h5678, 4'b0000, 4'b0000,
              0, 3, 16'h1111, 4'b0000, 1, 3, 16'h2222, 4'b0000);
    // Frame 3: 2222; load on the wrap edge.
    run_frame(16'h2222, 4'b0000, 4'b0000,
              3, 7, 16'h00A0, 4'b0000, -1, 0, 16'h0, 4'h0);
    // Frame 4: still 2222, wrap-cycle load deferred one frame.
    run_frame(16'h2222, 4'b0000, 4'b0000,
              -1, 0, 16'h0, 4'h0, -1, 0, 16'h0, 4'h0);
    // Frame 5: 00A0, code A blanked; load 0045.
    run_frame(16'h00A0, 4'b0000, LZ ? 4'b1110 : 4'b0010,
              1, 2, 16'h0045, 4'b0000, -1, 0, 16'h0, 4'h0);
    // Frame 6: 0045; load 0045 with a decimal point on digit 2.
    run_frame(16'h0045, 4'b0000, LZ ? 4'b1100 : 4'b0000,
              1, 5, 16'h0045, 4'b0100, -1, 0, 16'h0, 4'h0);
    // Frame 7: dp on digit 2 stops leading-zero blanking there.
    run_frame(16'h0045, 4'b0100, LZ ? 4'b1000 : 4'b0000,
              -1, 0, 16'h0, 4'h0, -1, 0, 16'h0, 4'h0);

    // Frame 8: reset in the middle of slot 2.
    check_slot(0, 4'h5, 1'b0, 1'b0, 0, 16'h0, 4'h0);
    check_slot(1, 4'h4, 1'b0, 1'b0, 0, 16'h0, 4'h0);
    tick(); tick(); tick();
    chk("pre_rst_en", 32'(digit_en), 32'h4);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check_slot(0, 4'h0, 1'b0, LZ ? 1'b0 : 1'b0, 0, 16'h0, 4'h0);
    check_slot(1, 4'h0, 1'b0, LZ ? 1'b1 : 1'b0, 0, 16'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
